// File: rtl/ddr_rd_stream_if.sv
// Bundle of the streamer's control, output stream and DDR channel signals.
// The slave modport is the streamer's view of the bundle; the master modport is the environment's view.
interface ddr_rd_stream_if;
    logic        start;
    logic [28:0] base;
    logic [23:0] len;
    logic        loop;
    logic        busy;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [28:0] ch_addr;
    logic [7:0]  ch_burst;
    logic        ch_req;
    logic [63:0] ch_data;
    logic        ch_ready;

    modport slave (
        input  start, base, len, loop, out_ready, ch_data, ch_ready,
        output busy, out_data, out_valid, ch_addr, ch_burst, ch_req
    );

    modport master (
        output start, base, len, loop, out_ready, ch_data, ch_ready,
        input  busy, out_data, out_valid, ch_addr, ch_burst, ch_req
    );
endinterface

// File: rtl/ddr_rd_stream.sv
// Linear DDR region reader: bursts qwords into a local FIFO through a toggle-request
// channel and serialises them into a 16-bit valid/ready stream, with optional looping.
module ddr_rd_stream #(
    parameter int unsigned BURST      = 64,
    parameter int unsigned FIFO_DEPTH = 128
) (
    input logic            clk,
    input logic            reset,
    ddr_rd_stream_if.slave bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FLUSH} state_t;

    state_t      r_state;
    logic        r_busy;
    logic        r_loop;
    logic [28:0] r_base;
    logic [28:0] r_cur;
    logic [23:0] r_len;
    logic [23:0] r_remain;

    // Request-channel state survives reset: the service detects requests by level
    // change, and beats already promised must still be drained before the next issue.
    logic [28:0] r_addr    = '0;
    logic [7:0]  r_burst   = '0;
    logic        r_req     = 1'b0;
    logic [7:0]  r_pending = '0;

    logic [63:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic [63:0] r_hold;
    logic [1:0]  r_lane;
    logic [15:0] r_odata;
    logic        r_ovalid;

    logic [7:0]    w_n;
    logic [CW-1:0] w_free;
    logic          w_issue;
    logic          w_beat;
    logic          w_wr;
    logic          w_last;
    logic          w_adv;
    logic          w_pop;
    logic          w_ser_done;

    always_comb begin
        w_n        = (r_remain >= 24'(BURST)) ? 8'(BURST) : r_remain[7:0];
        w_free     = CW'(FIFO_DEPTH) - r_count;
        w_issue    = !reset && (r_state == S_ISSUE) && (r_pending == '0)
                     && (32'(w_free) >= 32'(w_n));
        w_beat     = bus.ch_ready && (r_pending != '0);
        w_wr       = !reset && (r_state == S_WAIT) && w_beat;
        w_last     = w_wr && (r_pending == 8'd1);
        w_adv      = !r_ovalid || bus.out_ready;
        w_pop      = !reset && w_adv && (r_lane == 2'd0) && (r_count != '0);
        w_ser_done = (r_count == '0) && (r_lane == 2'd0) && w_adv;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_loop   <= 1'b0;
            r_base   <= '0;
            r_cur    <= '0;
            r_len    <= '0;
            r_remain <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start && bus.len != '0) begin
                        r_base   <= bus.base;
                        r_len    <= bus.len;
                        r_loop   <= bus.loop;
                        r_cur    <= bus.base;
                        r_remain <= bus.len;
                        r_busy   <= 1'b1;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_issue) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_last) begin
                        if (r_remain == 24'(r_burst)) begin
                            if (r_loop) begin
                                r_cur    <= r_base;
                                r_remain <= r_len;
                                r_state  <= S_ISSUE;
                            end else begin
                                r_state  <= S_FLUSH;
                            end
                        end else begin
                            r_cur    <= r_cur + 29'(r_burst);
                            r_remain <= r_remain - 24'(r_burst);
                            r_state  <= S_ISSUE;
                        end
                    end
                end
                S_FLUSH: begin
                    // Drop busy on the same edge that retires the final word.
                    if (w_ser_done) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_addr    <= r_cur;
            r_burst   <= w_n;
            r_req     <= ~r_req;
            r_pending <= w_n;
        end else if (w_beat) begin
            r_pending <= r_pending - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= bus.ch_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_hold   <= '0;
            r_lane   <= 2'd0;
            r_odata  <= '0;
            r_ovalid <= 1'b0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_wr) - CW'(w_pop);
            // r_lane is the next lane to present; 0 means a fresh qword is needed.
            if (w_adv) begin
                if (r_lane != 2'd0) begin
                    r_odata  <= r_hold[{r_lane, 4'b0000} +: 16];
                    r_lane   <= r_lane + 2'd1;
                    r_ovalid <= 1'b1;
                end else if (r_count != '0) begin
                    r_hold   <= r_mem[r_rptr];
                    r_odata  <= r_mem[r_rptr][15:0];
                    r_lane   <= 2'd1;
                    r_ovalid <= 1'b1;
                end else begin
                    r_ovalid <= 1'b0;
                end
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.out_data  = r_odata;
    assign bus.out_valid = r_ovalid;
    assign bus.ch_addr   = r_addr;
    assign bus.ch_burst  = r_burst;
    assign bus.ch_req    = r_req;
endmodule
